// File: rtl/fetch_unit_if.sv
// Fetch-side bus: instruction memory port plus decode handshake.
// master = fetch_unit, slave = memory/decode side.
interface fetch_unit_if #(
   parameter int dataWidth = 32,
   parameter int addrSize  = 32
);
   logic [addrSize-1:0]  imem_addr;
   logic [dataWidth-1:0] imem_instr;
   logic                 out_valid;
   logic                 out_ready;
   logic [dataWidth-1:0] out_instr;
   logic [addrSize-1:0]  out_pc;

   modport master (
      output imem_addr,
      input  imem_instr,
      output out_valid,
      input  out_ready,
      output out_instr,
      output out_pc
   );

   modport slave (
      input  imem_addr,
      output imem_instr,
      input  out_valid,
      output out_ready,
      input  out_instr,
      input  out_pc
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: owns the PC, registers imem words for decode.
// Optional FETCH_PERF_EN adds perf_fetched / perf_stalls counters.
module fetch_unit #(
   parameter int dataWidth = 32,
   parameter int addrSize  = 32,
   parameter logic [addrSize-1:0] RESET_PC = '0,
   parameter int PC_STEP = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                halt,
   input  logic                redirect_valid,
   input  logic [addrSize-1:0] redirect_pc,
   fetch_unit_if.master        bus,
   output logic                busy
`ifdef FETCH_PERF_EN
  ,output logic [31:0]         perf_fetched
  ,output logic [31:0]         perf_stalls
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_STALL
   } state_e;

   state_e               state_q, state_d;
   logic [addrSize-1:0]  pc_q, pc_d;
   logic [addrSize-1:0]  out_pc_q, out_pc_d;
   logic [dataWidth-1:0] out_instr_q, out_instr_d;
   logic                 out_valid_q, out_valid_d;
   logic                 cap;
   logic                 accept;
   logic [addrSize-1:0]  redir_pc;

   assign redir_pc = {redirect_pc[addrSize-1:2], 2'b00};
   assign accept   = out_valid_q && bus.out_ready;
   assign cap      = (state_q == S_FETCH)
                   && (!out_valid_q || bus.out_ready)
                   && !halt && !redirect_valid;

   assign bus.imem_addr = pc_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_instr = out_instr_q;
   assign bus.out_pc    = out_pc_q;
   assign busy          = (state_q != S_IDLE);

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      out_valid_d = out_valid_q;
      out_instr_d = out_instr_q;
      out_pc_d    = out_pc_q;

      if (accept)
         out_valid_d = 1'b0;

      if (cap) begin
         out_instr_d = bus.imem_instr;
         out_pc_d    = pc_q;
         out_valid_d = 1'b1;
         pc_d        = pc_q + addrSize'(PC_STEP);
      end

      // Redirect flushes the held word even when decode never took it.
      if (redirect_valid) begin
         pc_d        = redir_pc;
         out_valid_d = 1'b0;
         if (state_q != S_IDLE)
            state_d = S_FETCH;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start && !halt)
                  state_d = S_FETCH;
            end
            S_FETCH: begin
               if (out_valid_q && !bus.out_ready)
                  state_d = S_STALL;
               else if (halt)
                  state_d = S_IDLE;
            end
            S_STALL: begin
               if (bus.out_ready)
                  state_d = halt ? S_IDLE : S_FETCH;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         pc_q        <= RESET_PC;
         out_valid_q <= 1'b0;
         out_instr_q <= '0;
         out_pc_q    <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         out_valid_q <= out_valid_d;
         out_instr_q <= out_instr_d;
         out_pc_q    <= out_pc_d;
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched_q, perf_fetched_d;
   logic [31:0] perf_stalls_q, perf_stalls_d;

   always_comb begin
      perf_fetched_d = perf_fetched_q;
      perf_stalls_d  = perf_stalls_q;
      if (cap)
         perf_fetched_d = perf_fetched_q + 32'd1;
      if (state_q == S_STALL)
         perf_stalls_d = perf_stalls_q + 32'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetched_q <= '0;
         perf_stalls_q  <= '0;
      end else begin
         perf_fetched_q <= perf_fetched_d;
         perf_stalls_q  <= perf_stalls_d;
      end
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_stalls  = perf_stalls_q;
`endif

endmodule
